// File: rtl/mux_4bit_2to1.sv
// mux_4bit_2to1
//   Two-input word selector with a registered copy of the selected word and
//   an optional select-switch counter for debug statistics.
//
//   Optional feature macro: MUX_4BIT_2TO1_SWITCH_CNT_EN
//     defined   -> s_q / sw_cnt logic is built (saturating switch counter)
//     undefined -> counter omitted, sw_cnt tied to 0
//   The port list and the y / y_q behaviour are the same in both builds.
//
// Ports
//   clk     in  1      rising-edge clock for y_q and the counter
//   rst     in  1      asynchronous, active-high reset of all registers
//   a       in  WIDTH  data word selected when s = 0
//   b       in  WIDTH  data word selected when s = 1
//   s       in  1      select
//   y       out WIDTH  combinational selected word (independent of clk/rst)
//   y_q     out WIDTH  selected word registered on each rising edge
//   sw_cnt  out CNT_W  saturating count of s transitions seen at clock edges
//
// There is no handshake: every input is sampled on every rising edge.

module mux_4bit_2to1 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [CNT_W-1:0] sw_cnt
);

  // ---------------------------------------------------------------------
  // Combinational select.
  // A case statement (rather than ?:) keeps an X/Z select propagating as X
  // in simulation; a ternary would merge the two words bit by bit and hide
  // the unknown select wherever a and b happen to agree.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] y_d;

  always_comb begin
    y_d = {WIDTH{1'bx}};
    case (s)
      1'b0:    y_d = a;
      1'b1:    y_d = b;
      default: y_d = {WIDTH{1'bx}};
    endcase
  end

  assign y = y_d;

  // ---------------------------------------------------------------------
  // Registered copy of the selected word: y_q holds the value y had just
  // before the most recent rising edge.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] y_reg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg_q <= '0;
    end else begin
      y_reg_q <= y_d;
    end
  end

  assign y_q = y_reg_q;

  // ---------------------------------------------------------------------
  // Select-switch counter.
  // s_q starts at 0 out of reset, so a first edge sampling s = 1 counts as
  // one switch. The counter sticks at all-ones instead of wrapping so a
  // very busy select never reads as a quiet one.
  // ---------------------------------------------------------------------
`ifdef MUX_4BIT_2TO1_SWITCH_CNT_EN
  logic             s_q;
  logic             s_d;
  logic [CNT_W-1:0] sw_cnt_q;
  logic [CNT_W-1:0] sw_cnt_d;
  logic             switched;
  logic             saturated;

  assign switched  = (s != s_q);
  assign saturated = (sw_cnt_q == {CNT_W{1'b1}});

  always_comb begin
    s_d      = s;
    sw_cnt_d = sw_cnt_q;
    if (switched && !saturated) begin
      sw_cnt_d = sw_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= 1'b0;
      sw_cnt_q <= '0;
    end else begin
      s_q      <= s_d;
      sw_cnt_q <= sw_cnt_d;
    end
  end

  assign sw_cnt = sw_cnt_q;
`else
  assign sw_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_4bit_2to1.sv
module tb_mux_4bit_2to1;

  localparam int WIDTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MUX_4BIT_2TO1_SWITCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             clk_en;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [CNT_W-1:0] sw_cnt;

  initial begin
    clk    = 1'b0;
    clk_en = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  mux_4bit_2to1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .s      (s),
    .y      (y),
    .y_q    (y_q),
    .sw_cnt (sw_cnt)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {exp_y, exp_y_q, exp_sw_cnt}
  logic [2*WIDTH+CNT_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // Reference model state: what has been seen at clock edges so far.
  int model_cnt  = 0;
  bit model_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    model_cnt  = 0;
    model_prev = 1'b0;
  endtask

  // Driver: apply one word set away from the rising edge and push what the
  // outputs must show just after that edge.
  task automatic drive(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv);
    logic [WIDTH-1:0] ey;
    @(negedge clk);
    a = av;
    b = bv;
    s = sv;
    ey = sv ? bv : av;
    if (CNT_EN && (sv != model_prev) && (model_cnt < CNT_MAX)) model_cnt++;
    model_prev = sv;
    exp_q.push_back({ey, ey, CNT_W'(model_cnt)});
  endtask

  // Monitor: one popped expectation per rising edge while streaming.
  initial begin
    logic [2*WIDTH+CNT_W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stream_y",      32'(y),      32'(e[2*WIDTH+CNT_W-1 -: WIDTH]));
        check("stream_y_q",    32'(y_q),    32'(e[WIDTH+CNT_W-1 -: WIDTH]));
        check("stream_sw_cnt", 32'(sw_cnt), 32'(e[CNT_W-1:0]));
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [WIDTH-1:0] tbl_a[8];
  logic [WIDTH-1:0] tbl_b[8];

  initial begin
    tbl_a = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
    tbl_b = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF};

    rst = 1'b1;
    a   = '0;
    b   = '0;
    s   = 1'b0;
    #20;
    check("reset_y_q",    32'(y_q),    32'd0);
    check("reset_sw_cnt", 32'(sw_cnt), 32'd0);

    // Clockless combinational sweep: first four with s=0, next four with s=1.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = tbl_a[i];
      b = tbl_b[i];
      s = (i >= 4);
      #200;
      check("comb_y", 32'(y), 32'((i >= 4) ? tbl_b[i] : tbl_a[i]));
    end
    check("noclk_y_q_held", 32'(y_q), 32'd0);

    // Clocked reset pulse mid-run.
    clk_en = 1'b1;
    @(negedge clk);
    a = 4'b1010;
    b = 4'b0101;
    s = 1'b1;
    @(posedge clk);
    #1;
    check("run_y_q_loaded", 32'(y_q), 32'b0101);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_y_q",    32'(y_q),    32'd0);
    check("async_rst_y",      32'(y),      32'b0101);
    check("async_rst_sw_cnt", 32'(sw_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_y_q",    32'(y_q),    32'b0101);
    check("post_rst_sw_cnt", 32'(sw_cnt), CNT_EN ? 32'd1 : 32'd0);

    // Fresh reset with s=0, then stream.
    @(negedge clk);
    s   = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Toggle s every cycle: counter must climb to saturation and hold.
    for (int i = 0; i < 300; i++) begin
      drive(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)), ((i % 2) == 0));
    end
    drain();
    check("saturated_sw_cnt", 32'(sw_cnt), CNT_EN ? 32'(CNT_MAX) : 32'd0);

    // Random stimulus.
    for (int i = 0; i < 1000; i++) begin
      drive(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    drain();
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, failures=%0d", failures);
    $fatal(1, "timeout");
  end

endmodule
